// File: rtl/alu_arbiter_seq_if.sv
// Bus bundle for alu_arbiter_seq: two request channels, the shared-ALU port and the response channel.
// The req*_mul bits exist only when ALU_ARBITER_SEQ_MUL_EN is defined.
interface alu_arbiter_seq_if #(
   parameter int unsigned WIDTH = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [2:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [2:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
`ifdef ALU_ARBITER_SEQ_MUL_EN
   logic             req0_mul;
   logic             req1_mul;
`endif
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_sel;
   logic [WIDTH-1:0] alu_out;
   logic             alu_zero;
   logic             alu_overflow;
   logic             alu_carry;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic [2:0]       rsp_flags;

   // Requesters, ALU and response consumer together.
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req1_ready,
`ifdef ALU_ARBITER_SEQ_MUL_EN
      output req0_mul, req1_mul,
`endif
      input  alu_a, alu_b, alu_sel,
      output alu_out, alu_zero, alu_overflow, alu_carry,
      input  rsp_valid, rsp_id, rsp_data, rsp_flags,
      output rsp_ready
   );

   // The arbiter itself.
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req1_ready,
`ifdef ALU_ARBITER_SEQ_MUL_EN
      input  req0_mul, req1_mul,
`endif
      output alu_a, alu_b, alu_sel,
      input  alu_out, alu_zero, alu_overflow, alu_carry,
      output rsp_valid, rsp_id, rsp_data, rsp_flags,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_arbiter_seq.sv
// Round-robin sharing of one combinational ALU between two requesters, with a held response channel.
// Optional shift-add multiply through the same ALU when ALU_ARBITER_SEQ_MUL_EN is defined.
module alu_arbiter_seq #(
   parameter int unsigned WIDTH   = 4,
   parameter bit          RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   alu_arbiter_seq_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
`ifdef ALU_ARBITER_SEQ_MUL_EN
      , MUL = 2'd3
`endif
   } state_t;

   state_t           state;
   logic             prio;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       sel_q;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic [2:0]       rsp_flags_q;

   logic             any_valid_c;
   logic             grant_c;
   logic [2:0]       op_c;
   logic [WIDTH-1:0] a_c;
   logic [WIDTH-1:0] b_c;

   // Priority holder only matters when both requesters are valid.
   assign any_valid_c = bus.req0_valid | bus.req1_valid;
   assign grant_c     = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;
   assign op_c        = grant_c ? bus.req1_op : bus.req0_op;
   assign a_c         = grant_c ? bus.req1_a  : bus.req0_a;
   assign b_c         = grant_c ? bus.req1_b  : bus.req0_b;

   assign bus.req0_ready = ~rst & (state == IDLE) & bus.req0_valid & ~grant_c;
   assign bus.req1_ready = ~rst & (state == IDLE) & bus.req1_valid &  grant_c;

   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_sel   = sel_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_flags = rsp_flags_q;

`ifdef ALU_ARBITER_SEQ_MUL_EN
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic             mul_carry;
   logic             mul_c;
   logic             take_c;
   logic [WIDTH-1:0] acc_next_c;
   logic             carry_next_c;

   // alu_a doubles as the accumulator; the ALU adds the shifted partial when b[i] is set.
   assign mul_c        = grant_c ? bus.req1_mul : bus.req0_mul;
   assign take_c       = mul_b[cnt];
   assign acc_next_c   = take_c ? bus.alu_out : a_q;
   assign carry_next_c = mul_carry | (take_c & bus.alu_carry);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         prio        <= RR_INIT;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
`ifdef ALU_ARBITER_SEQ_MUL_EN
         cnt         <= '0;
         mul_a       <= '0;
         mul_b       <= '0;
         mul_carry   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_valid_c) begin
                  prio     <= ~grant_c;
                  rsp_id_q <= grant_c;
                  sel_q    <= op_c;
                  a_q      <= a_c;
                  b_q      <= b_c;
                  state    <= EXEC;
`ifdef ALU_ARBITER_SEQ_MUL_EN
                  if (mul_c) begin
                     sel_q     <= 3'b000;
                     a_q       <= '0;
                     b_q       <= a_c;
                     mul_a     <= a_c;
                     mul_b     <= b_c;
                     cnt       <= '0;
                     mul_carry <= 1'b0;
                     state     <= MUL;
                  end
`endif
               end
            end
            EXEC: begin
               rsp_data_q  <= bus.alu_out;
               rsp_flags_q <= {bus.alu_overflow, bus.alu_carry, bus.alu_zero};
               rsp_valid_q <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
`ifdef ALU_ARBITER_SEQ_MUL_EN
            MUL: begin
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  rsp_data_q  <= acc_next_c;
                  rsp_flags_q <= {1'b0, carry_next_c, acc_next_c == '0};
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  a_q       <= acc_next_c;
                  b_q       <= mul_a << (cnt + CNT_W'(1));
                  cnt       <= cnt + CNT_W'(1);
                  mul_carry <= carry_next_c;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Self-checking bench for alu_arbiter_seq: directed scenarios then random traffic against a transaction-level model.
// Also exercises the multiply path when ALU_ARBITER_SEQ_MUL_EN is defined.
module tb_alu_arbiter_seq;
   localparam int unsigned W       = 4;
   localparam int          MOD     = 1 << W;
   localparam bit          RR_INIT = 1'b0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_arbiter_seq_if #(.WIDTH(W)) bus ();
   alu_arbiter_seq #(.WIDTH(W), .RR_INIT(RR_INIT)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Stimulus
   bit           v0, v1, rr, mul0, mul1;
   logic [2:0]   op0, op1;
   logic [W-1:0] a0, b0, a1, b1;

   assign bus.req0_valid = v0;
   assign bus.req0_op    = op0;
   assign bus.req0_a     = a0;
   assign bus.req0_b     = b0;
   assign bus.req1_valid = v1;
   assign bus.req1_op    = op1;
   assign bus.req1_a     = a1;
   assign bus.req1_b     = b1;
   assign bus.rsp_ready  = rr;
`ifdef ALU_ARBITER_SEQ_MUL_EN
   assign bus.req0_mul   = mul0;
   assign bus.req1_mul   = mul1;
`endif

   // Shared ALU seen by the arbiter, written bit-level.
   function automatic logic [W+1:0] alu_fn(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         ov, c;
      ov = 1'b0;
      c  = 1'b0;
      s  = '0;
      case (sel)
         3'd0: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[W-1:0];
            c  = s[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd1: begin
            s  = {1'b0, a} - {1'b0, b};
            r  = s[W-1:0];
            c  = s[W];
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd2:    r = ~a;
         3'd3:    r = a & b;
         3'd4:    r = a | b;
         3'd5:    r = a ^ b;
         3'd6:    r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         default: r = (a == b) ? W'(1) : W'(0);
      endcase
      return {r, ov, c};
   endfunction

   logic [W+1:0] alu_res;
   always_comb begin
      alu_res          = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);
      bus.alu_out      = alu_res[W+1:2];
      bus.alu_overflow = alu_res[1];
      bus.alu_carry    = alu_res[0];
      bus.alu_zero     = (alu_res[W+1:2] == '0);
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Expected op results from integer arithmetic.
   task automatic op_ref(input logic [2:0] op, input int a, input int b,
                         output logic [W-1:0] d, output logic [2:0] f);
      int r, sa, sb;
      bit ov, c;
      sa = (a >= MOD / 2) ? a - MOD : a;
      sb = (b >= MOD / 2) ? b - MOD : b;
      ov = 1'b0;
      c  = 1'b0;
      case (op)
         3'd0: begin r = a + b; c = (r >= MOD); ov = (sa + sb > MOD / 2 - 1) || (sa + sb < -(MOD / 2)); end
         3'd1: begin r = a - b; c = (r < 0);    ov = (sa - sb > MOD / 2 - 1) || (sa - sb < -(MOD / 2)); end
         3'd2:    r = MOD - 1 - a;
         3'd3:    r = a & b;
         3'd4:    r = a | b;
         3'd5:    r = a ^ b;
         3'd6:    r = (sa < sb) ? 1 : 0;
         default: r = (a == b) ? 1 : 0;
      endcase
      r = ((r % MOD) + MOD) % MOD;
      d = W'(r);
      f = {ov, c, r == 0};
   endtask

   // Shift-add product: truncated partials, sticky carry out of any accumulate.
   task automatic mul_ref(input int a, input int b, output logic [W-1:0] d, output logic [2:0] f);
      int acc;
      bit c;
      acc = 0;
      c   = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
         if (((b >> i) & 1) == 1) begin
            acc = acc + ((a << i) % MOD);
            if (acc >= MOD) begin
               c   = 1'b1;
               acc = acc - MOD;
            end
         end
      end
      d = W'(acc);
      f = {1'b0, c, acc == 0};
   endtask

   // Transaction-level model: busy flag, remaining latency, pending response.
   bit           m_busy, m_rv, m_id, m_prio, m_mul;
   int           m_wait;
   logic [W-1:0] m_data, m_pdata, m_a, m_b;
   logic [2:0]   m_flags, m_pflags, m_sel;

   task automatic model_step();
      bit g;
      if (rst) begin
         m_busy = 1'b0; m_rv = 1'b0; m_wait = 0; m_prio = RR_INIT; m_id = 1'b0; m_mul = 1'b0;
         m_data = '0; m_flags = '0; m_a = '0; m_b = '0; m_sel = '0;
      end else if (!m_busy) begin
         if (v0 || v1) begin
            g      = (v0 && v1) ? m_prio : v1;
            m_id   = g;
            m_prio = !g;
            m_busy = 1'b1;
            m_mul  = g ? mul1 : mul0;
            m_a    = g ? a1 : a0;
            m_b    = g ? b1 : b0;
            m_sel  = g ? op1 : op0;
            if (m_mul) begin
               mul_ref(int'(m_a), int'(m_b), m_pdata, m_pflags);
               m_wait = W;
            end else begin
               op_ref(m_sel, int'(m_a), int'(m_b), m_pdata, m_pflags);
               m_wait = 1;
            end
         end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            m_rv    = 1'b1;
            m_data  = m_pdata;
            m_flags = m_pflags;
         end
      end else if (rr) begin
         m_rv   = 1'b0;
         m_busy = 1'b0;
      end
   endtask

   task automatic check_now();
      bit g;
      g = (v0 && v1) ? m_prio : v1;
      chk("req0_ready", 32'(bus.req0_ready), 32'(!rst && !m_busy && v0 && !g));
      chk("req1_ready", 32'(bus.req1_ready), 32'(!rst && !m_busy && v1 && g));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
      if (m_rv) begin
         chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
         chk("rsp_data", 32'(bus.rsp_data), 32'(m_data));
         chk("rsp_flags", 32'(bus.rsp_flags), 32'(m_flags));
      end
      if (m_busy && m_wait > 0 && !m_mul) begin
         chk("alu_a", 32'(bus.alu_a), 32'(m_a));
         chk("alu_b", 32'(bus.alu_b), 32'(m_b));
         chk("alu_sel", 32'(bus.alu_sel), 32'(m_sel));
      end
   endtask

   // One clock: check settled outputs mid-cycle, then advance the model at the edge.
   task automatic cyc();
      @(negedge clk);
      #1;
      check_now();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic txn(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit mul);
      v0 = 1'b0; v1 = 1'b0; mul0 = 1'b0; mul1 = 1'b0;
      if (id) begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; mul1 = mul; end
      else    begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; mul0 = mul; end
      cyc();
      chk("lat_early", 32'(bus.rsp_valid), 32'd0);
      v0 = 1'b0; v1 = 1'b0; mul0 = 1'b0; mul1 = 1'b0;
      repeat (mul ? W : 1) cyc();
   endtask

   bit ids[$];
   task automatic collect(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         if (bus.rsp_valid && rr) ids.push_back(bus.rsp_id);
      end
   endtask

   initial begin
      rst = 1'b1; rr = 1'b1;
      v0 = 1'b0; v1 = 1'b0; mul0 = 1'b0; mul1 = 1'b0;
      op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      @(posedge clk);
      model_step();
      #1;
      cyc();
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_flags", 32'(bus.rsp_flags), 32'd0);
      chk("rst_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
      chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
      rst = 1'b0;

      // Add 3+5: signed overflow, no carry
      txn(1'b0, 3'd0, W'(3), W'(5), 1'b0);
      chk("add_valid", 32'(bus.rsp_valid), 32'd1);
      chk("add_id", 32'(bus.rsp_id), 32'd0);
      chk("add_data", 32'(bus.rsp_data), 32'd8);
      chk("add_flags", 32'(bus.rsp_flags), 32'b100);
      cyc();
      chk("add_done", 32'(bus.rsp_valid), 32'd0);

      txn(1'b1, 3'd1, W'(5), W'(5), 1'b0);
      chk("sub_data", 32'(bus.rsp_data), 32'd0);
      chk("sub_flags", 32'(bus.rsp_flags), 32'b001);
      chk("sub_id", 32'(bus.rsp_id), 32'd1);
      cyc();
      txn(1'b1, 3'd7, W'(9), W'(9), 1'b0);
      chk("eq_data", 32'(bus.rsp_data), 32'd1);
      chk("eq_flags", 32'(bus.rsp_flags), 32'b000);
      cyc();

      // Round robin from reset with both requesters held valid
      rst = 1'b1; cyc(); rst = 1'b0;
      v0 = 1'b1; v1 = 1'b1; op0 = 3'd4; a0 = W'(1); b0 = W'(2); op1 = 3'd3; a1 = W'(6); b1 = W'(3);
      ids.delete();
      collect(12);
      chk("rr_count", 32'(ids.size()), 32'd4);
      if (ids.size() == 4) begin
         chk("rr_g0", 32'(ids[0]), 32'd0);
         chk("rr_g1", 32'(ids[1]), 32'd1);
         chk("rr_g2", 32'(ids[2]), 32'd0);
         chk("rr_g3", 32'(ids[3]), 32'd1);
      end
      ids.delete();
      v0 = 1'b0;
      collect(6);
      v0 = 1'b1;
      collect(3);
      chk("rr2_count", 32'(ids.size()), 32'd3);
      if (ids.size() == 3) begin
         chk("rr2_g0", 32'(ids[0]), 32'd1);
         chk("rr2_g1", 32'(ids[1]), 32'd1);
         chk("rr2_g2", 32'(ids[2]), 32'd0);
      end

      // Backpressure: response held, no grants while stalled
      rr = 1'b0;
      txn(1'b0, 3'd5, W'(6), W'(3), 1'b0);
      v0 = 1'b1; v1 = 1'b1; op1 = 3'd2; a1 = W'(10);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("bp_data", 32'(bus.rsp_data), 32'd5);
         chk("bp_id", 32'(bus.rsp_id), 32'd0);
         chk("bp_flags", 32'(bus.rsp_flags), 32'b000);
      end
      rr = 1'b1;
      cyc();
      chk("bp_release", 32'(bus.rsp_valid), 32'd0);
      cyc();
      chk("bp_resume_id", 32'(bus.rsp_id), 32'd1);
      v0 = 1'b0; v1 = 1'b0;
      repeat (4) cyc();

      // Reset during EXEC aborts the op and restores priority
      v0 = 1'b1; op0 = 3'd0; a0 = W'(2); b0 = W'(2);
      cyc();
      v0 = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
      chk("abort_alu_a", 32'(bus.alu_a), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("abort_quiet", 32'(bus.rsp_valid), 32'd0);
      end
      v0 = 1'b1; v1 = 1'b1;
      cyc();
      chk("abort_prio", 32'(bus.rsp_id), 32'd0);
      v0 = 1'b0; v1 = 1'b0;
      repeat (3) cyc();

`ifdef ALU_ARBITER_SEQ_MUL_EN
      txn(1'b0, 3'd6, W'(3), W'(5), 1'b1);
      chk("mul_valid", 32'(bus.rsp_valid), 32'd1);
      chk("mul_data", 32'(bus.rsp_data), 32'd15);
      chk("mul_flags", 32'(bus.rsp_flags), 32'b000);
      cyc();
      txn(1'b1, 3'd1, W'(7), W'(3), 1'b1);
      chk("mul2_data", 32'(bus.rsp_data), 32'd5);
      chk("mul2_flags", 32'(bus.rsp_flags), 32'b010);
      cyc();
`endif

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rst  = ($urandom_range(0, 63) == 0);
         v0   = ($urandom_range(0, 2) != 0);
         v1   = ($urandom_range(0, 2) != 0);
         op0  = 3'($urandom);
         op1  = 3'($urandom);
         a0   = W'($urandom);
         b0   = W'($urandom);
         a1   = W'($urandom);
         b1   = W'($urandom);
         rr   = ($urandom_range(0, 3) != 0);
`ifdef ALU_ARBITER_SEQ_MUL_EN
         mul0 = ($urandom_range(0, 3) == 0);
         mul1 = ($urandom_range(0, 3) == 0);
`endif
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
